// File: rtl/special_counter_gen.sv
// Multi-mode sequencer: binary up/down, Gray and Johnson, with parallel load and terminal count.
// Define SPECIAL_COUNTER_SAT_EN to make the binary/Gray modes saturate instead of wrapping.
module special_counter_gen #(
  parameter int          WIDTH   = 3,
  parameter int unsigned MAX_VAL = 2**WIDTH-1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [1:0]       Mode,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC
);

  localparam logic [WIDTH-1:0] MAX    = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] J_WRAP = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef SPECIAL_COUNTER_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic [WIDTH-1:0] cnt, jr, cnt_nxt, jr_nxt, q_nxt;
  logic [1:0]       mode_r, mode_nxt;
  logic             wrap, mode_chg;

  assign mode_chg = (Mode != mode_r);

  always_comb begin
    case (mode_r)
      2'b01:   wrap = (cnt == '0);
      2'b11:   wrap = (jr == J_WRAP);
      default: wrap = (cnt == MAX);
    endcase
  end

  assign TC = Enable & Reset & ~Load & ~mode_chg & wrap;

  always_comb begin
    cnt_nxt  = cnt;
    jr_nxt   = jr;
    mode_nxt = mode_r;
    if (Load) begin
      cnt_nxt  = (D > MAX) ? MAX : D;
      jr_nxt   = D;
      mode_nxt = Mode;
    end else if (mode_chg) begin
      cnt_nxt  = '0;
      jr_nxt   = '0;
      mode_nxt = Mode;
    end else if (Enable) begin
      case (mode_r)
        2'b01: begin
          if (cnt == '0) cnt_nxt = SAT ? cnt : MAX;
          else           cnt_nxt = cnt - ONE;
        end
        2'b11: jr_nxt = {jr[WIDTH-2:0], ~jr[WIDTH-1]};
        default: begin
          if (cnt == MAX) cnt_nxt = SAT ? cnt : '0;
          else            cnt_nxt = cnt + ONE;
        end
      endcase
    end
  end

  // Q is registered from the post-edge state so it always matches the active encoding.
  always_comb begin
    case (mode_nxt)
      2'b10:   q_nxt = cnt_nxt ^ (cnt_nxt >> 1);
      2'b11:   q_nxt = jr_nxt;
      default: q_nxt = cnt_nxt;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      cnt    <= '0;
      jr     <= '0;
      mode_r <= Mode;
      Q      <= '0;
    end else begin
      cnt    <= cnt_nxt;
      jr     <= jr_nxt;
      mode_r <= mode_nxt;
      Q      <= q_nxt;
    end
  end

endmodule
